wb_regbank: RTL and testbench

- Parametrised Wishbone-slave register bank. Generalises the fixed 3-register, zero-wait template to N registers.
- Each register has its own reset value, writable-bit mask and write-1-to-clear (W1C) mask.
- Access timing is registered, with a configurable number of wait states.
- Sits between the bus interconnect and peripheral logic; exposes all register contents in parallel and accepts hardware event inputs for W1C status bits.

---
 rtl/wb_regbank.sv | 172 +++++++++++++++++
 tb/tb_wb_regbank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regbank.sv
// wb_regbank: Wishbone-slave register bank with NREGS 32-bit registers.
// Each register has its own reset value, software-writable mask and
// write-1-to-clear mask. Accesses are acknowledged 1 + WAIT_STATES cycles
// after the accept edge. All register contents are exported on regs_o.
// Optional build macro WB_REGBANK_ERR_EN adds err_o, which replaces ack_o for
// out-of-range accesses.
module wb_regbank #(
  parameter int                  NREGS        = 4,
  parameter logic [NREGS*32-1:0] RESET_VALUES = {NREGS{32'h0}},
  parameter logic [NREGS*32-1:0] WMASK        = {NREGS{32'hFFFFFFFF}},
  parameter logic [NREGS*32-1:0] W1C_MASK     = {NREGS{32'h0}},
  parameter int                  WAIT_STATES  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [29:0]           adr_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  output logic                  ack_o,
  output logic [NREGS*32-1:0]   regs_o,
  input  logic [NREGS*32-1:0]   hw_set_i
`ifdef WB_REGBANK_ERR_EN
  ,
  output logic                  err_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] NREGS_U   = NREGS;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Request fields captured at the accept edge; data path, so no reset.
  logic [29:0] adr_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;

  logic [NREGS-1:0][31:0] regs_q, regs_d;

  logic        accept;
  logic        in_ack;
  logic        in_range;
  logic        wr_en;
  logic [31:0] lane_m;
  logic [31:0] rd_mux;

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  assign accept   = (state_q == S_IDLE) && cyc_i && stb_i;
  assign in_ack   = (state_q == S_ACK);
  assign in_range = ({2'b00, adr_q} < NREGS_U);
  assign wr_en    = in_ack && we_q && in_range;
  assign lane_m   = lane_mask(sel_q);

  // FSM state and wait counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, count wait states (abort if the master lets go), ack once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cyc_i && stb_i) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!(cyc_i && stb_i)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the request on the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      adr_q <= adr_i;
      we_q  <= we_i;
      sel_q <= sel_i;
      dat_q <= dat_i;
    end
  end

  // Read mux over the full address; anything out of range reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (adr_q == 30'(k)) begin
        rd_mux = regs_q[k];
      end
    end
  end

  // Register next value: masked software write, W1C clear, then hardware set wins.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NREGS; k++) begin
      regs_d[k] =
        (((regs_q[k] & ~({32{wr_en && (adr_q == 30'(k))}} & lane_m &
                         WMASK[32*k +: 32] & ~W1C_MASK[32*k +: 32]))
          | (dat_q & {32{wr_en && (adr_q == 30'(k))}} & lane_m &
             WMASK[32*k +: 32] & ~W1C_MASK[32*k +: 32]))
         & ~({32{wr_en && (adr_q == 30'(k))}} & dat_q & lane_m & W1C_MASK[32*k +: 32]))
        | (hw_set_i[32*k +: 32] & W1C_MASK[32*k +: 32]);
    end
  end

  // Register storage with per-register reset values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= RESET_VALUES;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs_o = regs_q;
  assign dat_o  = in_ack ? rd_mux : 32'h0;

`ifdef WB_REGBANK_ERR_EN
  assign ack_o = in_ack && in_range;
  assign err_o = in_ack && !in_range;
`else
  assign ack_o = in_ack;
`endif

endmodule

// File: tb/tb_wb_regbank.sv
// tb_wb_regbank: directed bench for wb_regbank. Two instances share the bus
// signals: dut0 with no wait states and dut3 with three. Each has its own
// strobe and reset so only the addressed instance sees a transfer.
// Build macro WB_REGBANK_ERR_EN switches the out-of-range expectations.
module tb_wb_regbank;

  localparam logic [127:0] RV  = {32'hDEADDEAD, 32'h03051996, 32'h12345678, 32'h00000000};
  localparam logic [127:0] WM  = {32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [127:0] W1C = {32'h000000FF, 96'h0};
`ifdef WB_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst0_n, rst3_n;
  logic         cyc, stb0, stb3, we;
  logic [29:0]  adr;
  logic [3:0]   sel;
  logic [31:0]  dat;
  logic [127:0] hw_set;
  logic [31:0]  dat0, dat3;
  logic         ack0, ack3;
  logic [127:0] regs0, regs3;
  logic         err0, err3;

  typedef struct {
    logic [31:0] rdata;
    bit          rd;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  wb_regbank #(
    .NREGS(4), .RESET_VALUES(RV), .WMASK(WM), .W1C_MASK(W1C), .WAIT_STATES(0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst0_n), .cyc_i(cyc), .stb_i(stb0), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_i(dat), .dat_o(dat0), .ack_o(ack0),
    .regs_o(regs0), .hw_set_i(hw_set)
`ifdef WB_REGBANK_ERR_EN
    , .err_o(err0)
`endif
  );

  wb_regbank #(
    .NREGS(4), .RESET_VALUES(RV), .WMASK(WM), .W1C_MASK(W1C), .WAIT_STATES(3)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .cyc_i(cyc), .stb_i(stb3), .we_i(we),
    .adr_i(adr), .sel_i(sel), .dat_i(dat), .dat_o(dat3), .ack_o(ack3),
    .regs_o(regs3), .hw_set_i(hw_set)
`ifdef WB_REGBANK_ERR_EN
    , .err_o(err3)
`endif
  );

`ifndef WB_REGBANK_ERR_EN
  assign err0 = 1'b0;
  assign err3 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transfer on dut0 (d3=0) or dut3 (d3=1). hw_ack is driven on
  // hw_set during the acknowledge cycle.
  task automatic xfer(input bit d3, input bit w, input logic [29:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      input logic [31:0] erd, input logic [127:0] hw_ack);
    exp_t e, got;
    bit   seen;
    int   lat;
    e.rdata = w ? 32'h0 : erd;
    e.rd    = !w;
    e.err   = ERR_EN && (a >= 30'd4);
    e.lat   = d3 ? 4 : 1;
    @(negedge clk);
    cyc = 1'b1; we = w; adr = a; sel = s; dat = wd;
    if (d3) stb3 = 1'b1; else stb0 = 1'b1;
    sbq.push_back(e);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if ((d3 ? (ack3 | err3) : (ack0 | err0)) === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    got = sbq.pop_front();
    chk("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", lat, got.lat);
      chk("ack", 32'(d3 ? ack3 : ack0), 32'(!got.err));
`ifdef WB_REGBANK_ERR_EN
      chk("err", 32'(d3 ? err3 : err0), 32'(got.err));
`endif
      if (got.rd) chk("rdata", d3 ? dat3 : dat0, got.rdata);
      hw_set = hw_ack;
    end
    cyc = 1'b0; stb0 = 1'b0; stb3 = 1'b0; we = 1'b0;
    @(negedge clk);
    hw_set = '0;
    chk("ack_pulse", 32'(d3 ? ack3 : ack0), 32'd0);
    chk("dat_idle", d3 ? dat3 : dat0, 32'd0);
  endtask

  initial begin
    bit seen;
    rst0_n = 1'b0; rst3_n = 1'b0;
    cyc = 1'b0; stb0 = 1'b0; stb3 = 1'b0; we = 1'b0;
    adr = '0; sel = '0; dat = '0; hw_set = '0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_dat0", dat0, 32'd0);
    chk("rst_ack3", 32'(ack3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_regs0", regs0[32*k +: 32], RV[32*k +: 32]);
    end

    // Reset values read back through the bus
    xfer(0, 0, 30'd0, 4'hF, 32'h0, 32'h00000000, '0);
    xfer(0, 0, 30'd1, 4'hF, 32'h0, 32'h12345678, '0);
    xfer(0, 0, 30'd2, 4'hF, 32'h0, 32'h03051996, '0);
    xfer(0, 0, 30'd3, 4'hF, 32'h0, 32'hDEADDEAD, '0);

    // Byte lanes
    xfer(0, 1, 30'd1, 4'b0101, 32'hAABBCCDD, 32'h0, '0);
    chk("lanes_regs_o", regs0[63:32], 32'h12BB56DD);
    xfer(0, 0, 30'd1, 4'hF, 32'h0, 32'h12BB56DD, '0);

    // Writable mask
    xfer(0, 1, 30'd2, 4'hF, 32'hFFFFFFFF, 32'h0, '0);
    xfer(0, 0, 30'd2, 4'hF, 32'h0, 32'h0305FFFF, '0);

    // W1C: clear low byte and zero the normal bits, then set via hardware
    xfer(0, 1, 30'd3, 4'hF, 32'h000000FF, 32'h0, '0);
    chk("w1c_clear_all", regs0[127:96], 32'h00000000);
    @(negedge clk);
    hw_set = 128'h9 << 96;
    @(negedge clk);
    hw_set = '0;
    chk("w1c_hw_set", regs0[127:96], 32'h00000009);
    xfer(0, 1, 30'd3, 4'hF, 32'h00000001, 32'h0, '0);
    chk("w1c_sw_clear", regs0[127:96], 32'h00000008);
    xfer(0, 1, 30'd3, 4'hF, 32'h00000008, 32'h0, 128'h8 << 96);
    chk("w1c_set_wins", regs0[127:96], 32'h00000008);

    // hw_set on non-W1C bits has no effect
    @(negedge clk);
    hw_set = (128'h100 << 96) | (128'h2 << 32);
    @(negedge clk);
    hw_set = '0;
    chk("hw_nonw1c_r3", regs0[127:96], 32'h00000008);
    chk("hw_nonw1c_r1", regs0[63:32], 32'h12BB56DD);

    // Out of range: small and high addresses, reads and writes
    xfer(0, 0, 30'd7, 4'hF, 32'h0, 32'h0, '0);
    xfer(0, 0, 30'h10000001, 4'hF, 32'h0, 32'h0, '0);
    xfer(0, 1, 30'd7, 4'hF, 32'hFFFFFFFF, 32'h0, '0);
    xfer(0, 1, 30'h10000002, 4'hF, 32'h00000000, 32'h0, '0);
    chk("oor_r0", regs0[31:0],   32'h00000000);
    chk("oor_r1", regs0[63:32],  32'h12BB56DD);
    chk("oor_r2", regs0[95:64],  32'h0305FFFF);
    chk("oor_r3", regs0[127:96], 32'h00000008);

    // Wait states: latency 4
    xfer(1, 0, 30'd1, 4'hF, 32'h0, 32'h12345678, '0);
    xfer(1, 0, 30'd3, 4'hF, 32'h0, 32'hDEADDEAD, '0);

    // Abort: strobe drops in the second wait cycle of a write
    @(negedge clk);
    cyc = 1'b1; stb3 = 1'b1; we = 1'b1; adr = 30'd1; sel = 4'hF; dat = 32'hFFFFFFFF;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack3 !== 1'b0) seen = 1'b1;
      if (i == 2) begin
        cyc = 1'b0; stb3 = 1'b0; we = 1'b0;
      end
    end
    chk("abort_noack", 32'(seen), 32'd0);
    chk("abort_reg1", regs3[63:32], 32'h12345678);

    // Reset asserted mid-wait
    @(negedge clk);
    cyc = 1'b1; stb3 = 1'b1; we = 1'b1; adr = 30'd1; sel = 4'hF; dat = 32'hAAAAAAAA;
    @(negedge clk);
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack3), 32'd0);
    cyc = 1'b0; stb3 = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rst_mid_reg1", regs3[63:32], 32'h12345678);
    rst3_n = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ack3 !== 1'b0) seen = 1'b1;
    end
    chk("rst_mid_noack", 32'(seen), 32'd0);
    xfer(1, 0, 30'd1, 4'hF, 32'h0, 32'h12345678, '0);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
